// File: rtl/if_stage_mq_if.sv
// rtl/if_stage_mq_if.sv - SRAM-like instruction bus between if_stage_mq and the inst bridge
interface if_stage_mq_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );
endinterface

// File: rtl/if_stage_mq.sv
// rtl/if_stage_mq.sv - multi-outstanding fetch stage with fetch queue and redirect flush
// Optional same-cycle response-to-decode bypass: define IF_FQ_BYPASS_EN.
module if_stage_mq #(
    parameter int          OUTSTANDING = 2,
    parameter int          FQ_DEPTH    = 4,
    parameter logic [31:0] RESET_PC    = 32'hbfc00000,
    parameter logic [31:0] EX_ENTRY    = 32'hbfc00380
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ds_allowin,
    input  logic          fetch_stall,
    input  logic          ws_ex,
    input  logic          eret,
    input  logic [31:0]   cp0_epc,
    input  logic          br_redirect,
    input  logic [31:0]   br_target,
    output logic          fs_to_ds_valid,
    output logic [101:0]  fs_to_ds_bus,
    if_stage_mq_if.master inst
);
    localparam int          QW    = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int          CW    = $clog2(FQ_DEPTH + 1);
    localparam int          SW    = CW + 2;
    localparam logic [4:0]  NO_EX = 5'h1f;
    localparam logic [4:0]  ADEL  = 5'h04;
    localparam logic [2:0]  OUT_L = 3'(OUTSTANDING);

    logic [31:0]   req_pc_q, req_pc_d;
    logic          pend_q, pend_d, pend_stale_q, pend_stale_d;
    logic [31:0]   pend_addr_q, pend_addr_d;
    logic          halted_q, halted_d;
    logic [2:0]    inflight_q, inflight_d, discard_q, discard_d;
    logic [31:0]   pf_mem [4];
    logic [1:0]    pf_wr_q, pf_rd_q;
    logic [101:0]  fq_mem [FQ_DEPTH];
    logic [QW-1:0] fq_head_q, fq_head_d, fq_tail_q, fq_tail_d;
    logic [CW-1:0] fq_cnt_q, fq_cnt_d;

    logic          redirect, issue_ok, req, accept, resp, resp_live, byp;
    logic          data_enq, mis_enq, enq, deq;
    logic [31:0]   target, addr, resp_pc;
    logic [101:0]  enq_entry, byp_entry;
    logic [SW-1:0] occupancy;

    always_comb begin
        redirect  = ws_ex | eret | br_redirect;
        target    = ws_ex ? EX_ENTRY : (eret ? cp0_epc : br_target);
        occupancy = SW'(fq_cnt_q) + SW'(inflight_q);
        issue_ok  = !halted_q && !fetch_stall && (inflight_q < OUT_L) &&
                    (occupancy < SW'(FQ_DEPTH)) && (req_pc_q[1:0] == 2'b00);
        req       = !reset && (pend_q || issue_ok);
        addr      = pend_q ? pend_addr_q : req_pc_q;
        accept    = req && inst.inst_sram_addr_ok;
        resp      = inst.inst_sram_data_ok && (inflight_q != 3'd0);
        resp_pc   = pf_mem[pf_rd_q];
        // Responses are stale if owed to an earlier redirect, or arrive in a redirect cycle
        resp_live = resp && (discard_q == 3'd0) && !redirect;
`ifdef IF_FQ_BYPASS_EN
        byp       = resp_live && (fq_cnt_q == '0) && ds_allowin;
`else
        byp       = 1'b0;
`endif
        data_enq  = resp_live && !byp;
        mis_enq   = !redirect && !halted_q && !pend_q && (req_pc_q[1:0] != 2'b00) &&
                    (fq_cnt_q < CW'(FQ_DEPTH)) && !data_enq;
        enq       = data_enq || mis_enq;
        deq       = (fq_cnt_q != '0) && ds_allowin && !redirect;
        byp_entry = {1'b0, 32'b0, NO_EX, inst.inst_sram_rdata, resp_pc};
        enq_entry = data_enq ? byp_entry : {1'b1, req_pc_q, ADEL, 32'b0, req_pc_q};
    end

    always_comb begin
        inflight_d   = inflight_q + {2'b0, accept} - {2'b0, resp};
        pend_d       = req && !inst.inst_sram_addr_ok;
        pend_addr_d  = addr;
        pend_stale_d = pend_d && (redirect || (pend_q && pend_stale_q));
        req_pc_d     = req_pc_q;
        discard_d    = discard_q;
        halted_d     = halted_q;
        fq_head_d    = fq_head_q;
        fq_tail_d    = fq_tail_q;
        fq_cnt_d     = fq_cnt_q;
        if (redirect) begin
            // Everything accepted up to and including this cycle belongs to the old stream
            req_pc_d  = target;
            discard_d = inflight_d;
            halted_d  = 1'b0;
            fq_head_d = '0;
            fq_tail_d = '0;
            fq_cnt_d  = '0;
        end else begin
            if (accept && !(pend_q && pend_stale_q))
                req_pc_d = req_pc_q + 32'd4;
            discard_d = discard_q - {2'b0, resp && (discard_q != 3'd0)}
                                  + {2'b0, accept && pend_q && pend_stale_q};
            if (mis_enq)
                halted_d = 1'b1;
            fq_head_d = fq_head_q + QW'(deq);
            fq_tail_d = fq_tail_q + QW'(enq);
            fq_cnt_d  = fq_cnt_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_pc_q     <= RESET_PC;
            pend_q       <= 1'b0;
            pend_stale_q <= 1'b0;
            pend_addr_q  <= RESET_PC;
            halted_q     <= 1'b0;
            inflight_q   <= 3'd0;
            discard_q    <= 3'd0;
            pf_wr_q      <= 2'd0;
            pf_rd_q      <= 2'd0;
            fq_head_q    <= '0;
            fq_tail_q    <= '0;
            fq_cnt_q     <= '0;
        end else begin
            req_pc_q     <= req_pc_d;
            pend_q       <= pend_d;
            pend_stale_q <= pend_stale_d;
            pend_addr_q  <= pend_addr_d;
            halted_q     <= halted_d;
            inflight_q   <= inflight_d;
            discard_q    <= discard_d;
            pf_wr_q      <= pf_wr_q + {1'b0, accept};
            pf_rd_q      <= pf_rd_q + {1'b0, resp};
            fq_head_q    <= fq_head_d;
            fq_tail_q    <= fq_tail_d;
            fq_cnt_q     <= fq_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept)
            pf_mem[pf_wr_q] <= addr;
        if (!reset && enq)
            fq_mem[fq_tail_q] <= enq_entry;
    end

    assign fs_to_ds_valid        = !reset && ((fq_cnt_q != '0) || byp);
    assign fs_to_ds_bus          = byp ? byp_entry : fq_mem[fq_head_q];
    assign inst.inst_sram_req    = req;
    assign inst.inst_sram_addr   = addr;
    assign inst.inst_sram_wr     = 1'b0;
    assign inst.inst_sram_size   = 2'b10;
    assign inst.inst_sram_wstrb  = 4'b0;
    assign inst.inst_sram_wdata  = 32'b0;
endmodule

// File: tb/tb_if_stage_mq.sv
// tb/tb_if_stage_mq.sv - randomized scoreboard bench for if_stage_mq with in-order bridge model
module tb_if_stage_mq;
    localparam int          OUTSTANDING = 2;
    localparam int          FQ_DEPTH    = 4;
    localparam logic [31:0] RESET_PC    = 32'hbfc00000;
    localparam logic [31:0] EX_ENTRY    = 32'hbfc00380;
`ifdef IF_FQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, ds_allowin, fetch_stall, ws_ex, eret, br_redirect;
    logic [31:0]  cp0_epc, br_target;
    logic         fs_to_ds_valid;
    logic [101:0] fs_to_ds_bus;

    if_stage_mq_if sram_if ();

    if_stage_mq #(.OUTSTANDING(OUTSTANDING), .FQ_DEPTH(FQ_DEPTH),
                  .RESET_PC(RESET_PC), .EX_ENTRY(EX_ENTRY)) dut (
        .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .fetch_stall(fetch_stall),
        .ws_ex(ws_ex), .eret(eret), .cp0_epc(cp0_epc), .br_redirect(br_redirect),
        .br_target(br_target), .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .inst(sram_if)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; int rdy; int cy; } acc_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int aok_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    acc_t br_q[$];
    acc_t acc_log[$];
    logic [101:0] exp_q[$];
    logic [31:0] next_pc;
    bit stream_live;

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5ac3c3;
    endfunction

    task automatic chk(input string name, input logic [101:0] act, input logic [101:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // In-order bridge: random addr_ok, random response latency
    initial begin
        logic prev_pend;
        logic [31:0] prev_addr;
        acc_t e;
        prev_pend = 1'b0;
        prev_addr = 32'b0;
        sram_if.inst_sram_addr_ok = 1'b0;
        sram_if.inst_sram_data_ok = 1'b0;
        sram_if.inst_sram_rdata   = 32'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                br_q.delete();
                sram_if.inst_sram_addr_ok = 1'b0;
                sram_if.inst_sram_data_ok = 1'b0;
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("req_hold", {69'b0, sram_if.inst_sram_req, sram_if.inst_sram_addr},
                        {69'b0, 1'b1, prev_addr});
                end
                if (br_q.size() > 0 && br_q[0].rdy <= cyc) begin
                    e = br_q.pop_front();
                    sram_if.inst_sram_data_ok = 1'b1;
                    sram_if.inst_sram_rdata   = inst_of(e.a);
                end else begin
                    sram_if.inst_sram_data_ok = 1'b0;
                    sram_if.inst_sram_rdata   = $urandom;
                end
                sram_if.inst_sram_addr_ok = ($urandom_range(99) < aok_pct);
                if (sram_if.inst_sram_req && sram_if.inst_sram_addr_ok) begin
                    e.a   = sram_if.inst_sram_addr;
                    e.rdy = cyc + $urandom_range(lat_max, lat_min);
                    e.cy  = cyc;
                    br_q.push_back(e);
                    acc_log.push_back(e);
                    chk("outstanding_le_max", 102'(br_q.size() <= OUTSTANDING), 102'(1));
                end
                prev_pend = sram_if.inst_sram_req && !sram_if.inst_sram_addr_ok;
                prev_addr = sram_if.inst_sram_addr;
            end
        end
    end

    // Monitor: every decode handshake pops the next expected entry
    initial begin
        logic [101:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && fs_to_ds_valid && ds_allowin && !(ws_ex || eret || br_redirect)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery: got %h expected none", fs_to_ds_bus);
                end else begin
                    e = exp_q.pop_front();
                    chk("delivered_entry", fs_to_ds_bus, e);
                end
            end
        end
    end

    task automatic topup();
        while (stream_live && exp_q.size() < 16) begin
            if (next_pc[1:0] != 2'b00) begin
                exp_q.push_back({1'b1, next_pc, 5'h04, 32'b0, next_pc});
                stream_live = 1'b0;
            end else begin
                exp_q.push_back({1'b0, 32'b0, 5'h1f, inst_of(next_pc), next_pc});
                next_pc = next_pc + 32'd4;
            end
        end
    endtask

    task automatic start_stream(input logic [31:0] pc);
        exp_q.delete();
        next_pc = pc;
        stream_live = 1'b1;
        topup();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        topup();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_redirect(input bit ex, input bit er, input bit br,
                               input logic [31:0] epc, input logic [31:0] bt, input bit post_allow);
        ws_ex = ex; eret = er; br_redirect = br;
        cp0_epc = epc; br_target = bt;
        ds_allowin = 1'b0;
        start_stream(ex ? EX_ENTRY : (er ? epc : bt));
        @(posedge clk);
        #1;
        ws_ex = 1'b0; eret = 1'b0; br_redirect = 1'b0;
        ds_allowin = post_allow;
        @(negedge clk);
        #2;
        chk("flushed_after_redirect", 102'(fs_to_ds_valid), 102'(0));
    endtask

    function automatic int count_acc(input logic [31:0] a, input logic [31:0] mask);
        int n = 0;
        foreach (acc_log[i]) if ((acc_log[i].a & mask) == (a & mask)) n++;
        return n;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        reset = 1'b1; ds_allowin = 1'b0; fetch_stall = 1'b0;
        ws_ex = 1'b0; eret = 1'b0; br_redirect = 1'b0;
        cp0_epc = 32'b0; br_target = 32'b0;
        stream_live = 1'b0;
        next_pc = RESET_PC;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        chk("reset_req", 102'(sram_if.inst_sram_req), 102'(0));
        chk("reset_valid", 102'(fs_to_ds_valid), 102'(0));

        // Zero-latency bridge, back-to-back issue
        step();
        reset = 1'b0;
        ds_allowin = 1'b1;
        start_stream(RESET_PC);
        steps(12);
        chk("acc_log_len", 102'(acc_log.size() >= 3), 102'(1));
        if (acc_log.size() >= 3) begin
            chk("first_addr0", 102'(acc_log[0].a), 102'(32'hbfc00000));
            chk("first_addr1", 102'(acc_log[1].a), 102'(32'hbfc00004));
            chk("first_addr2", 102'(acc_log[2].a), 102'(32'hbfc00008));
            chk("back_to_back1", 102'(acc_log[1].cy - acc_log[0].cy), 102'(1));
            chk("back_to_back2", 102'(acc_log[2].cy - acc_log[1].cy), 102'(1));
        end

        // Decode blocked: exactly FQ_DEPTH fresh requests, then req drops
        acc_log.delete();
        do_redirect(1'b0, 1'b0, 1'b1, 32'b0, 32'h80000000, 1'b0);
        steps(12);
        chk("full_queue_accepts", 102'(count_acc(32'h80000000, 32'hfffff000)), 102'(FQ_DEPTH));
        chk("full_queue_req_low", 102'(sram_if.inst_sram_req), 102'(0));
        ds_allowin = 1'b1;
        steps(15);

        // Redirect with two requests in flight
        lat_min = 3; lat_max = 3;
        steps(6);
        chk("two_inflight", 102'(br_q.size()), 102'(2));
        lat_min = 1; lat_max = 1;
        do_redirect(1'b0, 1'b0, 1'b1, 32'b0, 32'h80001000, 1'b1);
        steps(15);

        // Exception outranks ERET
        do_redirect(1'b1, 1'b1, 1'b0, 32'h80002000, 32'b0, 1'b1);
        steps(15);

        // Misaligned ERET target
        acc_log.delete();
        do_redirect(1'b0, 1'b1, 1'b0, 32'h80000002, 32'b0, 1'b1);
        steps(15);
        chk("misaligned_entry_taken", 102'(exp_q.size()), 102'(0));
        chk("misaligned_no_fetch", 102'(count_acc(32'h80000000, 32'hfffff000)), 102'(0));
        chk("misaligned_req_low", 102'(sram_if.inst_sram_req), 102'(0));

        // Response-to-decode latency with an empty queue
        fetch_stall = 1'b1;
        do_redirect(1'b0, 1'b0, 1'b1, 32'b0, 32'h80003000, 1'b1);
        steps(10);
        fetch_stall = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #2;
            seen = sram_if.inst_sram_req && sram_if.inst_sram_addr_ok;
        end
        @(posedge clk);
        #1;
        fetch_stall = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #2;
            seen = sram_if.inst_sram_data_ok;
        end
        chk("data_ok_seen", 102'(seen), 102'(1));
        chk("valid_in_data_ok_cycle", 102'(fs_to_ds_valid), 102'(BYP));
        @(negedge clk);
        #2;
        chk("valid_cycle_after", 102'(fs_to_ds_valid), 102'(!BYP));
        step();
        fetch_stall = 1'b0;
        steps(5);

        // Randomized traffic
        lat_min = 1; lat_max = 4;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(99) < 3) begin
                logic [31:0] t;
                t = {16'h8000, 4'h0, 10'($urandom), 2'b00};
                if ($urandom_range(7) == 0) t[1:0] = 2'($urandom_range(3, 1));
                case ($urandom_range(3))
                    0: do_redirect(1'b1, 1'($urandom), 1'($urandom), t, t ^ 32'h00000ff0, 1'b1);
                    1: do_redirect(1'b0, 1'b1, 1'($urandom), t, t ^ 32'h00000ff0, 1'b1);
                    default: do_redirect(1'b0, 1'b0, 1'b1, 32'h0, t, 1'b1);
                endcase
            end
            step();
            ds_allowin  = ($urandom_range(99) < 70);
            fetch_stall = ($urandom_range(99) < 10);
            if ($urandom_range(49) == 0) aok_pct = $urandom_range(100, 30);
        end

        // Reset in the middle of traffic
        step();
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("midrun_reset_req", 102'(sram_if.inst_sram_req), 102'(0));
        chk("midrun_reset_valid", 102'(fs_to_ds_valid), 102'(0));
        step();
        reset = 1'b0;
        fetch_stall = 1'b0;
        ds_allowin = 1'b1;
        start_stream(RESET_PC);
        steps(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
